// File: rtl/pad_input_conditioner.sv
// Pad input conditioner: per-bit synchroniser, glitch filter,
// edge pulses and software-clearable sticky event flags.
module pad_input_conditioner #(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_in,
  input  logic             filt_en,
  input  logic [WIDTH-1:0] clr_events,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] event_sticky
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_FILT = CW'(FILT_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]    r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_sticky;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_upd;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [CW-1:0]    w_last;
  logic [CW-1:0]    w_cnt_nxt [WIDTH];

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = w_s ^ r_level;
  // Bypass behaves as a one-cycle filter.
  assign w_last = filt_en ? LAST_FILT : '0;
  assign w_rise = w_upd & w_s;
  assign w_fall = w_upd & ~w_s;

  // Plain flop chain re-timing the asynchronous pad levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= RESET_VAL;
      end
    end else begin
      r_sync[0] <= pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Stability count: accept a new level after enough mismatching cycles;
  // ">=" lets a shrinking filter length take effect at once.
  always_comb begin
    w_upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (w_diff[i]) begin
        if (r_cnt[i] >= w_last) begin
          w_upd[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Counter and filtered level registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_level <= r_level ^ w_upd;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Edge pulses and sticky flags; a set beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rise   <= '0;
      r_fall   <= '0;
      r_sticky <= '0;
    end else begin
      r_rise   <= w_rise;
      r_fall   <= w_fall;
      r_sticky <= (r_sticky & ~clr_events) | w_rise | w_fall;
    end
  end

  assign level_out    = r_level;
  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign event_sticky = r_sticky;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Bench for pad_input_conditioner: directed vector table,
// hand sequences and randomized run against a behavioural model.
module tb_pad_input_conditioner;

  localparam int         W  = 4;
  localparam int         S  = 2;
  localparam int         F  = 4;
  localparam logic [3:0] RV = 4'b0101;

  logic       clk;
  logic       rst_n;
  logic [3:0] pad_in;
  logic       filt_en;
  logic [3:0] clr_events;
  logic [3:0] level_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] event_sticky;

  int checks;
  int errors;

  pad_input_conditioner #(
    .WIDTH      (W),
    .SYNC_STAGES(S),
    .FILT_CYCLES(F),
    .RESET_VAL  (RV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pad_in      (pad_in),
    .filt_en     (filt_en),
    .clr_events  (clr_events),
    .level_out   (level_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .event_sticky(event_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pad history queue gives the synchronised
  // view; per bit, a run length of disagreeing cycles.
  logic [3:0] m_q [$];
  logic [3:0] m_level;
  logic [3:0] m_rise;
  logic [3:0] m_fall;
  logic [3:0] m_sticky;
  int         m_run [W];

  task automatic model_edge(input logic r, input logic [3:0] p,
                            input logic f, input logic [3:0] c);
    logic [3:0] s;
    int n;
    if (!r) begin
      m_q.delete();
      for (int k = 0; k < S; k++) m_q.push_back(RV);
      m_level  = RV;
      m_rise   = '0;
      m_fall   = '0;
      m_sticky = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      s = m_q.pop_front();
      m_q.push_back(p);
      n = f ? F : 1;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (s[i] == m_level[i]) begin
          m_run[i] = 0;
        end else if (m_run[i] + 1 >= n) begin
          m_level[i] = s[i];
          m_run[i] = 0;
          if (s[i]) m_rise[i] = 1'b1;
          else m_fall[i] = 1'b1;
        end else begin
          m_run[i] = m_run[i] + 1;
        end
      end
      m_sticky = (m_sticky & ~c) | m_rise | m_fall;
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act,
                         input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // One clock: drive, clock, advance model, compare all outputs.
  task automatic step(input logic r, input logic [3:0] p,
                      input logic f, input logic [3:0] c);
    rst_n      = r;
    pad_in     = p;
    filt_en    = f;
    clr_events = c;
    @(posedge clk);
    model_edge(r, p, f, c);
    #1;
    chk("m_level", level_out, m_level);
    chk("m_rise", rise_pulse, m_rise);
    chk("m_fall", fall_pulse, m_fall);
    chk("m_sticky", event_sticky, m_sticky);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] pad;
    logic       fen;
    logic [3:0] clr;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] st;
  } vec_t;

  vec_t tbl [22];

  initial begin
    int rise_at;
    int fall_at;
    int nr;
    int nf;
    logic [3:0] p;
    logic f;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    pad_in = '0;
    filt_en = 1'b1;
    clr_events = '0;

    // reset with pad opposite of reset value, then release
    tbl[0]  = '{0, 4'b1010, 1, 4'b0000, RV, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{0, 4'b1010, 1, 4'b0000, RV, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{0, 4'b1010, 1, 4'b0000, RV, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{1, 4'b1010, 1, 4'b0000, RV, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{1, 4'b1010, 1, 4'b0000, RV, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{1, 4'b1010, 1, 4'b0000, RV, 4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{1, 4'b1010, 1, 4'b0000, RV, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{1, 4'b1010, 1, 4'b0000, RV, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{1, 4'b1010, 1, 4'b0000,
                4'b1010, 4'b1010, 4'b0101, 4'b1111};
    tbl[9]  = '{1, 4'b1010, 1, 4'b0000,
                4'b1010, 4'b0000, 4'b0000, 4'b1111};
    tbl[10] = '{1, 4'b1010, 1, 4'b1111,
                4'b1010, 4'b0000, 4'b0000, 4'b0000};
    // bypass: bit 2 rises at edge 3
    tbl[11] = '{1, 4'b1110, 0, 4'b0000,
                4'b1010, 4'b0000, 4'b0000, 4'b0000};
    tbl[12] = '{1, 4'b1110, 0, 4'b0000,
                4'b1010, 4'b0000, 4'b0000, 4'b0000};
    tbl[13] = '{1, 4'b1110, 0, 4'b0000,
                4'b1110, 4'b0100, 4'b0000, 4'b0100};
    tbl[14] = '{1, 4'b1110, 0, 4'b0000,
                4'b1110, 4'b0000, 4'b0000, 4'b0100};
    // all bits to 0, then all bits to 1 at once
    tbl[15] = '{1, 4'b0000, 0, 4'b0100,
                4'b1110, 4'b0000, 4'b0000, 4'b0000};
    tbl[16] = '{1, 4'b0000, 0, 4'b0000,
                4'b1110, 4'b0000, 4'b0000, 4'b0000};
    tbl[17] = '{1, 4'b0000, 0, 4'b0000,
                4'b0000, 4'b0000, 4'b1110, 4'b1110};
    tbl[18] = '{1, 4'b1111, 0, 4'b1110,
                4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[19] = '{1, 4'b1111, 0, 4'b0000,
                4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[20] = '{1, 4'b1111, 0, 4'b0000,
                4'b1111, 4'b1111, 4'b0000, 4'b1111};
    tbl[21] = '{1, 4'b1111, 0, 4'b0000,
                4'b1111, 4'b0000, 4'b0000, 4'b1111};

    for (int v = 0; v < 22; v++) begin
      step(tbl[v].rst, tbl[v].pad, tbl[v].fen, tbl[v].clr);
      chk($sformatf("tbl%0d_lvl", v), level_out, tbl[v].lvl);
      chk($sformatf("tbl%0d_rise", v), rise_pulse, tbl[v].rise);
      chk($sformatf("tbl%0d_fall", v), fall_pulse, tbl[v].fall);
      chk($sformatf("tbl%0d_st", v), event_sticky, tbl[v].st);
    end

    // quiesce at the reset value
    step(0, RV, 1, 4'b0000);
    step(0, RV, 1, 4'b0000);
    repeat (4) step(1, RV, 1, 4'b0000);

    // 3-cycle glitch on bit 1 is rejected
    for (int i = 1; i <= 10; i++) begin
      step(1, (i <= 3) ? 4'b0111 : 4'b0101, 1, 4'b0000);
      chk("glitch_lvl", level_out & 4'b0010, 4'b0000);
      chk("glitch_rise", rise_pulse & 4'b0010, 4'b0000);
    end

    // 4-cycle pulse on bit 1 passes: rise at 6, fall at 10
    rise_at = 0;
    fall_at = 0;
    nr = 0;
    nf = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1, (i <= 4) ? 4'b0111 : 4'b0101, 1, 4'b0000);
      if (rise_pulse[1]) begin
        rise_at = i;
        nr++;
      end
      if (fall_pulse[1]) begin
        fall_at = i;
        nf++;
      end
    end
    chk_int("pulse_rise_at", rise_at, 6);
    chk_int("pulse_fall_at", fall_at, 10);
    chk_int("pulse_nrise", nr, 1);
    chk_int("pulse_nfall", nf, 1);
    chk("pulse_st", event_sticky, 4'b0010);

    // sticky clear, then clear coincident with a new fall
    step(1, 4'b0101, 1, 4'b0010);
    chk("st_clr", event_sticky, 4'b0000);
    for (int i = 1; i <= 6; i++) step(1, 4'b0111, 1, 4'b0000);
    chk("st_rise", rise_pulse, 4'b0010);
    chk("st_set", event_sticky, 4'b0010);
    for (int i = 1; i <= 5; i++) step(1, 4'b0101, 1, 4'b0000);
    step(1, 4'b0101, 1, 4'b0010);
    chk("st_fall", fall_pulse, 4'b0010);
    chk("st_setwins", event_sticky, 4'b0010);
    step(1, 4'b0101, 1, 4'b0010);
    chk("st_clr2", event_sticky, 4'b0000);

    // reset in the middle of a count on bit 3
    for (int i = 1; i <= 4; i++) step(1, 4'b1101, 1, 4'b0000);
    step(0, 4'b1101, 1, 4'b0000);
    chk("rmid_lvl", level_out, RV);
    chk("rmid_rise", rise_pulse, 4'b0000);
    chk("rmid_fall", fall_pulse, 4'b0000);
    for (int i = 1; i <= 6; i++) begin
      step(1, 4'b1101, 1, 4'b0000);
      if (i == 5) chk("rmid_hold", level_out, RV);
    end
    chk("rmid_lvl6", level_out, 4'b1101);
    chk("rmid_rise6", rise_pulse, 4'b1000);

    // randomized run against the model
    p = pad_in;
    f = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) p = 4'($urandom);
      else if ($urandom_range(0, 7) == 0)
        p = p ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) f = ~f;
      step(($urandom_range(0, 199) != 0), p, f,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
